mem_access: RTL

- Memory stage directly downstream of EX.
- Consumes EX's write-back record (ex_wreg_o), ALU op (ex_alu_o) and effective address (ex_ramaddr_o), all delivered through the EX/MEM register.
- Runs LB/LW/SB/SW against a data RAM with a req/ack handshake and stalls the pipeline until the access completes.
- Passes every non-memory op to WB with zero latency.

---
 rtl/mem_access_pkg.sv | 49 ++++
 rtl/mem_lane_align.sv | 58 +++++
 rtl/mem_access.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/mem_access_pkg.sv
// Shared types for the memory stage: write-back record, ALU op, FSM states and byte-lane helpers.
package mem_access_pkg;

  typedef logic [31:0] reg_data_t;
  typedef logic [31:0] ram_addr_t;
  typedef logic [4:0]  reg_addr_t;

  typedef struct packed {
    logic      en;
    reg_addr_t addr;
    reg_data_t data;
  } reg_t;

  typedef enum logic [7:0] {
    NOP_OP = 8'h00,
    ADD_OP = 8'h01,
    SUB_OP = 8'h02,
    AND_OP = 8'h03,
    OR_OP  = 8'h04,
    LB_OP  = 8'h10,
    LW_OP  = 8'h11,
    SB_OP  = 8'h12,
    SW_OP  = 8'h13
  } alu_op_t;

  typedef struct packed {
    alu_op_t op;
  } alu_t;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } mem_state_t;

  typedef logic [3:0] byte_sel_t;

  localparam byte_sel_t SEL_WORD = 4'b1111;
  localparam byte_sel_t SEL_NONE = 4'b0000;

  function automatic logic is_mem_op(alu_op_t op);
    return op inside {LB_OP, LW_OP, SB_OP, SW_OP};
  endfunction

  function automatic logic is_store_op(alu_op_t op);
    return op inside {SB_OP, SW_OP};
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Big-endian byte-lane steering for loads/stores: byte enables, store replication,
// load sign extension and word-alignment check.
module mem_lane_align
  import mem_access_pkg::*;
(
  input  alu_op_t   op_i,
  input  logic [1:0] addr_lo_i,
  input  reg_data_t storedata_i,
  input  reg_data_t rdata_i,
  output byte_sel_t sel_o,
  output reg_data_t wdata_o,
  output reg_data_t load_o,
  output logic      misalign_o
);

  byte_sel_t  byte_sel;
  logic [7:0] lane_byte;

  always_comb begin
    byte_sel  = SEL_NONE;
    lane_byte = '0;
    case (addr_lo_i)
      2'b00: begin byte_sel = 4'b1000; lane_byte = rdata_i[31:24]; end
      2'b01: begin byte_sel = 4'b0100; lane_byte = rdata_i[23:16]; end
      2'b10: begin byte_sel = 4'b0010; lane_byte = rdata_i[15:8];  end
      default: begin byte_sel = 4'b0001; lane_byte = rdata_i[7:0]; end
    endcase
  end

  always_comb begin
    sel_o      = SEL_NONE;
    wdata_o    = '0;
    load_o     = '0;
    misalign_o = 1'b0;
    case (op_i)
      LB_OP: begin
        sel_o  = byte_sel;
        load_o = {{24{lane_byte[7]}}, lane_byte};
      end
      SB_OP: begin
        sel_o   = byte_sel;
        wdata_o = {4{storedata_i[7:0]}};
      end
      LW_OP: begin
        sel_o      = SEL_WORD;
        load_o     = rdata_i;
        misalign_o = |addr_lo_i;
      end
      SW_OP: begin
        sel_o      = SEL_WORD;
        wdata_o    = storedata_i;
        misalign_o = |addr_lo_i;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// Memory pipeline stage: runs LB/LW/SB/SW over a req/ack RAM port with timeout,
// stalling the pipeline; all other ops pass straight through to WB.
module mem_access
  import mem_access_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter int unsigned CNT_W          = 5
) (
  input  logic      clk,
  input  logic      rst,
  input  reg_t      mem_wreg_i,
  input  alu_t      mem_alu_i,
  input  ram_addr_t mem_ramaddr_i,
  input  reg_data_t mem_storedata_i,
  output reg_t      mem_wreg_o,
  output logic      mem_stallreq,
  output logic      mem_buserr_o,
  output logic      ram_req,
  output logic      ram_we,
  output ram_addr_t ram_addr,
  output byte_sel_t ram_sel,
  output reg_data_t ram_wdata,
  input  reg_data_t ram_rdata,
  input  logic      ram_ack
);

  mem_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             req_q, req_d;
  logic             we_q, we_d;
  byte_sel_t        sel_q, sel_d;
  ram_addr_t        addr_q, addr_d;
  reg_data_t        wdata_q, wdata_d;
  reg_data_t        rdata_q, rdata_d;
  logic             err_q, err_d;

  byte_sel_t lane_sel;
  reg_data_t lane_wdata;
  reg_data_t lane_load;
  logic      lane_misalign;
  logic      is_mem;
  logic      is_store;

  assign is_mem   = is_mem_op(mem_alu_i.op);
  assign is_store = is_store_op(mem_alu_i.op);

  // Load data is extracted from the captured word, relying on op/addr being held while stalled.
  mem_lane_align u_lane_align (
    .op_i        (mem_alu_i.op),
    .addr_lo_i   (mem_ramaddr_i[1:0]),
    .storedata_i (mem_storedata_i),
    .rdata_i     (rdata_q),
    .sel_o       (lane_sel),
    .wdata_o     (lane_wdata),
    .load_o      (lane_load),
    .misalign_o  (lane_misalign)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      sel_q   <= SEL_NONE;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      we_q    <= we_d;
      sel_q   <= sel_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    req_d        = req_q;
    we_d         = we_q;
    sel_d        = sel_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rdata_d      = rdata_q;
    err_d        = err_q;
    mem_wreg_o   = mem_wreg_i;
    mem_stallreq = 1'b0;
    mem_buserr_o = 1'b0;

    case (state_q)
      IDLE: begin
        if (is_mem) begin
          mem_wreg_o.en = 1'b0;
          if (lane_misalign) begin
            mem_buserr_o = 1'b1;
          end else begin
            mem_stallreq = 1'b1;
            state_d      = ACCESS;
            req_d        = 1'b1;
            we_d         = is_store;
            sel_d        = lane_sel;
            addr_d       = {mem_ramaddr_i[31:2], 2'b00};
            wdata_d      = lane_wdata;
            cnt_d        = '0;
            err_d        = 1'b0;
          end
        end
      end
      ACCESS: begin
        mem_stallreq  = 1'b1;
        mem_wreg_o.en = 1'b0;
        if (ram_ack) begin
          req_d   = 1'b0;
          state_d = DONE;
          if (!we_q) rdata_d = ram_rdata;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          req_d   = 1'b0;
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
        if (err_q) begin
          mem_wreg_o.en = 1'b0;
          mem_buserr_o  = 1'b1;
        end else if (is_store) begin
          mem_wreg_o.en = 1'b0;
        end else begin
          mem_wreg_o.data = lane_load;
        end
      end
      default: state_d = IDLE;
    endcase

    if (!rst) begin
      mem_wreg_o   = '0;
      mem_stallreq = 1'b0;
      mem_buserr_o = 1'b0;
    end
  end

  assign ram_req   = req_q;
  assign ram_we    = we_q;
  assign ram_addr  = addr_q;
  assign ram_sel   = sel_q;
  assign ram_wdata = wdata_q;

endmodule
